// File: rtl/if_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_unit
// Purpose  : Instruction fetch stage. Holds the PC, fetches words over a
//            req/ack instruction-memory handshake, and presents the decoded
//            field views of the fetched word through the IF/ID register.
//            Handles stall (one-entry skid buffer), flush and branch/jump
//            redirect, including a redirect while a fetch is in flight.
// Ports    : clk, rst (async, active-low)
//            imem_req/imem_addr -> memory ; imem_ack/imem_data <- memory
//            stall, flush, redirect, redirect_pc <- decode/execute
//            if_valid, field outputs, PC_out -> decode (IF/ID register)
// Revision : 1.0 - initial release
// ============================================================================
module if_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  R_I_A_type_rs,
  output logic [4:0]  R_type_rd,
  output logic [4:0]  R_I_type_rt,
  output logic [4:0]  R_type_shamt,
  output logic [5:0]  R_funct_S_snum,
  output logic [15:0] I_type_imm,
  output logic [25:0] J_type_imm,
  output logic [5:0]  S_type_index,
  output logic [9:0]  S_type_xcoor,
  output logic [9:0]  S_type_ycoor,
  output logic [7:0]  S_type_imm,
  output logic [20:0] A_type_imm,
  output logic [31:0] PC_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUF  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        drop, drop_nx;
  // Address of the request that was outstanding when a redirect arrived;
  // the bus must keep showing it until the stale ack comes back.
  logic [31:0] hold_addr, hold_addr_nx;
  logic [31:0] buf_word, buf_pc;
  logic        buf_load;

  logic        ifid_load;
  logic [31:0] ifid_word_nx, ifid_pc_nx;
  logic [31:0] ifid_word, ifid_pc;
  logic        ifid_valid;

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_nx      = drop;
    hold_addr_nx = hold_addr;
    buf_load     = 1'b0;
    ifid_load    = 1'b0;
    ifid_word_nx = imem_data;
    ifid_pc_nx   = pc;
    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          if (redirect || drop) begin
            // Word is for a path that is no longer wanted.
            drop_nx = 1'b0;
          end else if (stall) begin
            buf_load = 1'b1;
            state_nx = S_BUF;
          end else begin
            ifid_load = 1'b1;
            pc_nx     = pc + PC_STEP;
          end
        end else if (redirect && !drop) begin
          drop_nx      = 1'b1;
          hold_addr_nx = pc;
        end
      end
      S_BUF: begin
        if (redirect) begin
          state_nx = S_REQ;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_word_nx = buf_word;
          ifid_pc_nx   = buf_pc;
          pc_nx        = pc + PC_STEP;
          state_nx     = S_REQ;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (redirect) pc_nx = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      hold_addr <= 32'd0;
      buf_word  <= 32'd0;
      buf_pc    <= 32'd0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop      <= drop_nx;
      hold_addr <= hold_addr_nx;
      if (buf_load) begin
        buf_word <= imem_data;
        buf_pc   <= pc;
      end
    end
  end

  // IF/ID register: clear beats hold beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_valid <= 1'b0;
      ifid_word  <= 32'd0;
      ifid_pc    <= 32'd0;
    end else if (flush || redirect) begin
      ifid_valid <= 1'b0;
      ifid_word  <= 32'd0;
      ifid_pc    <= 32'd0;
    end else if (!stall && ifid_load) begin
      ifid_valid <= 1'b1;
      ifid_word  <= ifid_word_nx;
      ifid_pc    <= ifid_pc_nx;
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = drop ? hold_addr : pc;

  assign if_valid       = ifid_valid;
  assign PC_out         = ifid_pc;
  assign opcode         = ifid_word[31:26];
  assign R_I_A_type_rs  = ifid_word[25:21];
  assign R_type_rd      = ifid_word[20:16];
  assign R_I_type_rt    = ifid_word[15:11];
  assign R_type_shamt   = ifid_word[10:6];
  assign R_funct_S_snum = ifid_word[5:0];
  assign I_type_imm     = ifid_word[15:0];
  assign J_type_imm     = ifid_word[25:0];
  assign S_type_index   = ifid_word[25:20];
  assign S_type_xcoor   = ifid_word[19:10];
  assign S_type_ycoor   = ifid_word[9:0];
  assign S_type_imm     = ifid_word[7:0];
  assign A_type_imm     = ifid_word[20:0];

endmodule
`default_nettype wire

// File: tb/tb_if_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_if_unit
// Purpose  : Self-checking bench for if_unit: field-split vector table,
//            directed stall/flush/redirect/wrap/reset sequences, and a
//            randomized run against a transaction-level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [5:0]  opcode, R_funct_S_snum, S_type_index;
  logic [4:0]  R_I_A_type_rs, R_type_rd, R_I_type_rt, R_type_shamt;
  logic [15:0] I_type_imm;
  logic [25:0] J_type_imm;
  logic [9:0]  S_type_xcoor, S_type_ycoor;
  logic [7:0]  S_type_imm;
  logic [20:0] A_type_imm;
  logic [31:0] PC_out;

  // Second instance starting at the top of the address space.
  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_data, w_pc;
  logic        w_zero;
  logic [31:0] w_zero32;
  logic [5:0]  w_op, w_fn, w_si;
  logic [4:0]  w_rs, w_rd, w_rt, w_sh;
  logic [15:0] w_ii;
  logic [25:0] w_jj;
  logic [9:0]  w_sx, w_sy;
  logic [7:0]  w_sm;
  logic [20:0] w_ai;

  if_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .opcode(opcode), .R_I_A_type_rs(R_I_A_type_rs),
    .R_type_rd(R_type_rd), .R_I_type_rt(R_I_type_rt), .R_type_shamt(R_type_shamt),
    .R_funct_S_snum(R_funct_S_snum), .I_type_imm(I_type_imm), .J_type_imm(J_type_imm),
    .S_type_index(S_type_index), .S_type_xcoor(S_type_xcoor), .S_type_ycoor(S_type_ycoor),
    .S_type_imm(S_type_imm), .A_type_imm(A_type_imm), .PC_out(PC_out)
  );

  if_unit #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_data(w_data),
    .stall(w_zero), .flush(w_zero), .redirect(w_zero), .redirect_pc(w_zero32),
    .if_valid(w_valid), .opcode(w_op), .R_I_A_type_rs(w_rs),
    .R_type_rd(w_rd), .R_I_type_rt(w_rt), .R_type_shamt(w_sh),
    .R_funct_S_snum(w_fn), .I_type_imm(w_ii), .J_type_imm(w_jj),
    .S_type_index(w_si), .S_type_xcoor(w_sx), .S_type_ycoor(w_sy),
    .S_type_imm(w_sm), .A_type_imm(w_ai), .PC_out(w_pc)
  );

  logic [31:0] out_word;
  assign out_word = {opcode, J_type_imm};

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Every field view compared with the slice the instruction format defines.
  task automatic chk_fields(input string t, input logic [31:0] w);
    chk({t, ".op"},  {26'd0, opcode},         {26'd0, w[31:26]});
    chk({t, ".rs"},  {27'd0, R_I_A_type_rs},  {27'd0, w[25:21]});
    chk({t, ".rd"},  {27'd0, R_type_rd},      {27'd0, w[20:16]});
    chk({t, ".rt"},  {27'd0, R_I_type_rt},    {27'd0, w[15:11]});
    chk({t, ".sh"},  {27'd0, R_type_shamt},   {27'd0, w[10:6]});
    chk({t, ".fn"},  {26'd0, R_funct_S_snum}, {26'd0, w[5:0]});
    chk({t, ".ii"},  {16'd0, I_type_imm},     {16'd0, w[15:0]});
    chk({t, ".jj"},  {6'd0,  J_type_imm},     {6'd0,  w[25:0]});
    chk({t, ".si"},  {26'd0, S_type_index},   {26'd0, w[25:20]});
    chk({t, ".sx"},  {22'd0, S_type_xcoor},   {22'd0, w[19:10]});
    chk({t, ".sy"},  {22'd0, S_type_ycoor},   {22'd0, w[9:0]});
    chk({t, ".sm"},  {24'd0, S_type_imm},     {24'd0, w[7:0]});
    chk({t, ".ai"},  {11'd0, A_type_imm},     {11'd0, w[20:0]});
  endtask

  typedef struct {
    logic [31:0] word;
    logic [5:0]  op;
    logic [4:0]  rs, rd, rt, sh;
    logic [5:0]  fn;
    logic [15:0] ii;
    logic [25:0] jj;
    logic [5:0]  si;
    logic [9:0]  sx, sy;
    logic [7:0]  sm;
    logic [20:0] ai;
  } vec_t;

  vec_t tbl [5];

  task automatic chk_vec(input int i);
    chk("tbl.op", {26'd0, opcode},         {26'd0, tbl[i].op});
    chk("tbl.rs", {27'd0, R_I_A_type_rs},  {27'd0, tbl[i].rs});
    chk("tbl.rd", {27'd0, R_type_rd},      {27'd0, tbl[i].rd});
    chk("tbl.rt", {27'd0, R_I_type_rt},    {27'd0, tbl[i].rt});
    chk("tbl.sh", {27'd0, R_type_shamt},   {27'd0, tbl[i].sh});
    chk("tbl.fn", {26'd0, R_funct_S_snum}, {26'd0, tbl[i].fn});
    chk("tbl.ii", {16'd0, I_type_imm},     {16'd0, tbl[i].ii});
    chk("tbl.jj", {6'd0,  J_type_imm},     {6'd0,  tbl[i].jj});
    chk("tbl.si", {26'd0, S_type_index},   {26'd0, tbl[i].si});
    chk("tbl.sx", {22'd0, S_type_xcoor},   {22'd0, tbl[i].sx});
    chk("tbl.sy", {22'd0, S_type_ycoor},   {22'd0, tbl[i].sy});
    chk("tbl.sm", {24'd0, S_type_imm},     {24'd0, tbl[i].sm});
    chk("tbl.ai", {11'd0, A_type_imm},     {11'd0, tbl[i].ai});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference-model state for the random run.
  logic [31:0] exp_next;
  logic        stale, buffered;
  logic        p_ack, p_stall, p_redirect;
  logic [31:0] p_rpc;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_word;
  int          loads;

  initial begin
    tbl[0] = '{32'h0C00_0005, 6'h03, 5'h00, 5'h00, 5'h00, 5'h00, 6'h05, 16'h0005,
               26'h000_0005, 6'h00, 10'h000, 10'h005, 8'h05, 21'h00_0005};
    tbl[1] = '{32'h0000_0000, 6'h00, 5'h00, 5'h00, 5'h00, 5'h00, 6'h00, 16'h0000,
               26'h000_0000, 6'h00, 10'h000, 10'h000, 8'h00, 21'h00_0000};
    tbl[2] = '{32'h8A3F_C2A5, 6'h22, 5'h11, 5'h1F, 5'h18, 5'h0A, 6'h25, 16'hC2A5,
               26'h23F_C2A5, 6'h23, 10'h3F0, 10'h2A5, 8'hA5, 21'h1F_C2A5};
    tbl[3] = '{32'h1234_5678, 6'h04, 5'h11, 5'h14, 5'h0A, 5'h19, 6'h38, 16'h5678,
               26'h234_5678, 6'h23, 10'h115, 10'h278, 8'h78, 21'h14_5678};
    tbl[4] = '{32'hFFFF_FFFF, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF,
               26'h3FF_FFFF, 6'h3F, 10'h3FF, 10'h3FF, 8'hFF, 21'h1F_FFFF};

    rst = 1'b0; imem_ack = 1'b0; imem_data = 32'd0; stall = 1'b0; flush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0; w_ack = 1'b0; w_data = 32'd0;
    w_zero = 1'b0; w_zero32 = 32'd0;
    step(); step();

    // ---- reset state ----
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.pc",    PC_out, 32'd0);
    chk("rst.word",  out_word, 32'd0);
    chk("rst.req",   {31'd0, imem_req}, 32'd0);
    chk("rst.wvalid", {31'd0, w_valid}, 32'd0);
    rst = 1'b1;
    chk("idle.req",  {31'd0, imem_req}, 32'd0);
    step();

    // ---- field-split table, acked back to back ----
    for (int i = 0; i < 5; i++) begin
      chk("tbl.req",  {31'd0, imem_req}, 32'd1);
      chk("tbl.addr", imem_addr, i);
      imem_ack = 1'b1; imem_data = tbl[i].word;
      step();
      chk("tbl.valid", {31'd0, if_valid}, 32'd1);
      chk("tbl.pcout", PC_out, i);
      chk_vec(i);
    end
    imem_ack = 1'b0;

    // ---- wrap of the PC at the top of the address space ----
    chk("wrap.req",  {31'd0, w_req}, 32'd1);
    chk("wrap.addr0", w_addr, 32'hFFFF_FFFF);
    w_ack = 1'b1; w_data = memf(32'hFFFF_FFFF);
    step();
    w_ack = 1'b0;
    chk("wrap.pcout", w_pc, 32'hFFFF_FFFF);
    chk("wrap.valid", {31'd0, w_valid}, 32'd1);
    chk("wrap.addr1", w_addr, 32'd0);

    // ---- stall at ack: buffer, hold, release ----
    chk("stall.addr", imem_addr, 32'd5);
    imem_ack = 1'b1; imem_data = memf(32'd5); stall = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("stall.hold_pc", PC_out, 32'd4);
    chk("stall.req0",    {31'd0, imem_req}, 32'd0);
    step();
    chk("stall.hold2",   PC_out, 32'd4);
    chk("stall.word",    out_word, tbl[4].word);
    stall = 1'b0;
    step();
    chk("stall.rel_pc",  PC_out, 32'd5);
    chk("stall.rel_w",   out_word, memf(32'd5));
    chk("stall.rel_req", {31'd0, imem_req}, 32'd1);
    chk("stall.rel_adr", imem_addr, 32'd6);

    // ---- flush while stalled leaves the buffered word intact ----
    imem_ack = 1'b1; imem_data = memf(32'd6); stall = 1'b1;
    step();
    imem_ack = 1'b0; flush = 1'b1;
    step();
    chk("flush.valid", {31'd0, if_valid}, 32'd0);
    chk("flush.pc",    PC_out, 32'd0);
    chk("flush.word",  out_word, 32'd0);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("flush.buf_pc", PC_out, 32'd6);
    chk("flush.buf_w",  out_word, memf(32'd6));
    chk("flush.addr",   imem_addr, 32'd7);

    // ---- redirect while request to PC 7 is pending ----
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("redir.valid0", {31'd0, if_valid}, 32'd0);
    chk("redir.addr_hold", imem_addr, 32'd7);
    step();
    chk("redir.addr_hold2", imem_addr, 32'd7);
    imem_ack = 1'b1; imem_data = memf(32'd7);
    step();
    chk("redir.drop_valid", {31'd0, if_valid}, 32'd0);
    chk("redir.req",  {31'd0, imem_req}, 32'd1);
    chk("redir.addr_tgt", imem_addr, 32'h40);
    imem_data = memf(32'h40);
    step();
    chk("redir.tgt_pc",  PC_out, 32'h40);
    chk("redir.tgt_valid", {31'd0, if_valid}, 32'd1);
    chk_fields("redir", memf(32'h40));

    // ---- redirect in the same cycle as ack ----
    imem_data = memf(32'h41); redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("rack.valid", {31'd0, if_valid}, 32'd0);
    chk("rack.addr",  imem_addr, 32'h80);
    imem_data = memf(32'h80);
    step();
    imem_ack = 1'b0;
    chk("rack.pc",   PC_out, 32'h80);
    chk("rack.word", out_word, memf(32'h80));

    // ---- randomized run against the transaction-level model ----
    exp_next = 32'h81; stale = 1'b0; buffered = 1'b0; loads = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic load_ev, nbuf, nstale;
      s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
      s_pc = PC_out; s_word = out_word;
      p_ack      = imem_req && ($urandom_range(2) == 0);
      p_stall    = ($urandom_range(3) == 0);
      p_redirect = ($urandom_range(19) == 0);
      p_rpc      = $urandom;
      imem_ack = p_ack; imem_data = memf(imem_addr);
      stall = p_stall; redirect = p_redirect; redirect_pc = p_rpc;
      step();

      load_ev = !p_redirect && !p_stall && ((p_ack && !stale) || buffered);
      if (p_redirect) begin
        chk("rnd.clr_valid", {31'd0, if_valid}, 32'd0);
        chk("rnd.clr_pc",    PC_out, 32'd0);
        chk("rnd.clr_word",  out_word, 32'd0);
      end else if (load_ev) begin
        chk("rnd.valid", {31'd0, if_valid}, 32'd1);
        chk("rnd.pc",    PC_out, exp_next);
        chk_fields("rnd", memf(exp_next));
        chk("rnd.nreq",  {31'd0, imem_req}, 32'd1);
        chk("rnd.naddr", imem_addr, exp_next + 32'd1);
        loads++;
      end else begin
        chk("rnd.hold_valid", {31'd0, if_valid}, {31'd0, s_valid});
        chk("rnd.hold_pc",    PC_out, s_pc);
        chk("rnd.hold_word",  out_word, s_word);
      end
      if (s_req && !p_ack) begin
        chk("rnd.req_held",  {31'd0, imem_req}, 32'd1);
        chk("rnd.addr_held", imem_addr, s_addr);
      end
      if (p_ack && !stale && p_stall && !p_redirect)
        chk("rnd.buf_req0", {31'd0, imem_req}, 32'd0);
      if (p_redirect && !(s_req && !p_ack))
        chk("rnd.redir_addr", imem_addr, p_rpc);
      if (p_ack && stale && !p_redirect)
        chk("rnd.stale_addr", imem_addr, exp_next);

      nbuf = buffered;
      if (p_redirect) nbuf = 1'b0;
      else if (buffered && !p_stall) nbuf = 1'b0;
      else if (p_ack && !stale && p_stall) nbuf = 1'b1;
      nstale = stale;
      if (p_ack) nstale = 1'b0;
      if (p_redirect && s_req && !p_ack) nstale = 1'b1;
      if (p_redirect) exp_next = p_rpc;
      else if (load_ev) exp_next = exp_next + 32'd1;
      buffered = nbuf; stale = nstale;
    end
    imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    chk("rnd.progress", (loads > 200) ? 32'd1 : 32'd0, 32'd1);

    // ---- asynchronous reset in the middle of a cycle ----
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst.valid", {31'd0, if_valid}, 32'd0);
    chk("arst.pc",    PC_out, 32'd0);
    chk("arst.word",  out_word, 32'd0);
    chk("arst.req",   {31'd0, imem_req}, 32'd0);
    chk("arst.wpc",   w_pc, 32'd0);
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    rst = 1'b1;
    step();
    chk("arst.req1",  {31'd0, imem_req}, 32'd1);
    chk("arst.addr",  imem_addr, 32'd0);
    chk("arst.valid1", {31'd0, if_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
